tt_um_6bitsub_serial: RTL and testbench

Bit-serial 6-bit subtractor with borrow-in, the inverse operation to the team's 6-bit adder tile, packaged as a TinyTapeout user module on the standard pin set. A rising edge on a start pin latches two 6-bit operands and a borrow-in. The block then resolves one bit per clock, LSB first, and presents the difference, borrow-out and a result-valid flag on the dedicated outputs. A busy flag is driven on one bidirectional pin.

---
 rtl/tt_um_6bitsub_serial.sv | 153 +++++++++++++++
 tb/tb_tt_um_6bitsub_serial.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_6bitsub_serial.sv
// tt_um_6bitsub_serial: bit-serial 6-bit subtractor with borrow-in.
// A start edge latches A, B and BIN. One difference bit is resolved per
// clock, LSB first, over 6 cycles. D/BOUT/VALID are then presented on
// uo_out, and BUSY is presented on uio_out[7].
// Optional build macro SUB6_START_SYNC_EN adds a 2-flop synchronizer on
// START ahead of the edge detector, which adds 2 clocks of accept latency.
module tt_um_6bitsub_serial (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        prev_start_q, prev_start_d;
  logic        arm_q, arm_d;
  logic [5:0]  a_sh_q, a_sh_d;
  logic [5:0]  b_sh_q, b_sh_d;
  logic [5:0]  res_q, res_d;
  logic        br_q, br_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  dout_q, dout_d;
  logic        bout_q, bout_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        start_s;
  logic        start_edge;
  logic        bit_a, bit_b, bit_d, br_next;

  // ena and the upper subtrahend pins carry no function.
  logic        unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:6]};

`ifdef SUB6_START_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer on the raw START pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ui_in[7];
      sync2_q <= sync1_q;
    end
  end

  assign start_s = sync2_q;
`else
  assign start_s = ui_in[7];
`endif

  // The edge detector fires only after START has been seen low at least
  // once since reset. This keeps a START that is already high at reset
  // release from being taken as a fresh request.
  assign start_edge = start_s & ~prev_start_q & arm_q;

  // One full-subtractor slice on the current LSBs.
  assign bit_a   = a_sh_q[0];
  assign bit_b   = b_sh_q[0];
  assign bit_d   = bit_a ^ bit_b ^ br_q;
  assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  // Next-state logic: edge tracking, operand latch, and the per-bit shift.
  always_comb begin
    state_d      = state_q;
    prev_start_d = start_s;
    arm_d        = arm_q | ~ui_in[7];
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    bout_d       = bout_q;
    valid_d      = valid_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          a_sh_d  = ui_in[5:0];
          b_sh_d  = uio_in[5:0];
          br_d    = ui_in[6];
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = {bit_d, res_q[5:1]};
        a_sh_d = {1'b0, a_sh_q[5:1]};
        b_sh_d = {1'b0, b_sh_q[5:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          // The MSB is being resolved now, so assemble the final word directly.
          dout_d  = {bit_d, res_q[5:1]};
          bout_d  = br_next;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_start_q <= 1'b0;
      arm_q        <= 1'b0;
      a_sh_q       <= 6'd0;
      b_sh_q       <= 6'd0;
      res_q        <= 6'd0;
      br_q         <= 1'b0;
      cnt_q        <= 3'd0;
      dout_q       <= 6'd0;
      bout_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= prev_start_d;
      arm_q        <= arm_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      bout_q       <= bout_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign uo_out  = {valid_q, bout_q, dout_q};
  assign uio_out = {busy_q, 7'd0};
  assign uio_oe  = 8'b1000_0000;

endmodule

// File: tb/tb_tt_um_6bitsub_serial.sv
// Testbench for tt_um_6bitsub_serial. A countdown-style behavioural model
// predicts the outputs every cycle. Directed cases pin literal results, and
// a randomized exhaustive sweep covers all A/B/BIN combinations.
module tb_tt_um_6bitsub_serial;

`ifdef SUB6_START_SYNC_EN
  localparam int LAT  = 8;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 6;
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int vrises = 0;
  int brises = 0;

  tt_um_6bitsub_serial dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted request yields (A-B-BIN) mod 64 and the
  // borrow flag 6 clocks later; nothing else changes the visible outputs.
  logic       m_s1, m_s2, m_prev, m_arm;
  int         m_cnt;
  logic [5:0] m_a, m_b, m_d;
  logic       m_bin, m_bout, m_valid, m_busy;

  always @(posedge clk or negedge rst_n) begin
    logic st, ed;
    int diff;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_arm = 0; m_cnt = 0;
      m_a = 0; m_b = 0; m_d = 0; m_bin = 0; m_bout = 0;
      m_valid = 0; m_busy = 0;
    end else begin
      st = SYNC ? m_s2 : ui_in[7];
      ed = st && !m_prev && m_arm;
      m_prev = st;
      m_arm  = m_arm | !ui_in[7];
      m_s2   = m_s1;
      m_s1   = ui_in[7];
      if (m_cnt == 0) begin
        if (ed) begin
          m_a = ui_in[5:0]; m_b = uio_in[5:0]; m_bin = ui_in[6];
          m_cnt = 6; m_valid = 0; m_busy = 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          diff    = int'(m_a) - int'(m_b) - int'(m_bin);
          m_d     = 6'((diff + 128) % 64);
          m_bout  = (diff < 0);
          m_valid = 1; m_busy = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus rise counters for VALID/BUSY.
  always @(posedge clk) begin
    logic vl, bl;
    #1;
    check("uio_oe", int'(uio_oe), 8'h80);
    if (rst_n) begin
      check("uo_out", int'(uo_out), int'({m_valid, m_bout, m_d}));
      check("uio_out", int'(uio_out), int'({m_busy, 7'd0}));
    end
    if (uo_out[7] && !vl) vrises++;
    if (uio_out[7] && !bl) brises++;
    vl = uo_out[7];
    bl = uio_out[7];
  end

  task automatic wait_sig(input string name, input bit busy_not_valid, input int limit);
    bit ok;
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (busy_not_valid ? uio_out[7] : uo_out[7]) begin ok = 1; break; end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic do_op(input logic [5:0] a, input logic [5:0] b, input bit bin,
                       output logic [5:0] d, output bit bout, output int lat);
    bit seen_busy;
    seen_busy = 0;
    lat = -1;
    @(negedge clk);
    ui_in  = {1'b1, bin, a};
    uio_in = {2'b00, b};
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (uio_out[7]) seen_busy = 1;
      else if (seen_busy && uo_out[7]) begin lat = k - 1; break; end
      @(negedge clk);
      if (k == 1) ui_in[7] = 1'b0;
    end
    d    = uo_out[5:0];
    bout = uo_out[6];
  endtask

  task automatic op_lit(input string name, input logic [5:0] a, input logic [5:0] b,
                        input bit bin, input int exp_d, input int exp_bout);
    logic [5:0] d;
    bit bout;
    int lat;
    do_op(a, b, bin, d, bout, lat);
    check({name, "_d"}, int'(d), exp_d);
    check({name, "_bout"}, int'(bout), exp_bout);
    check({name, "_lat"}, lat, LAT);
    check({name, "_busy"}, int'(uio_out[7]), 0);
  endtask

  initial begin
    logic [5:0] d;
    bit bout;
    int lat, b0, v0, p, off, idx, diff;

    rst_n = 0; ui_in = 0; uio_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uo_out", int'(uo_out), 0);
    check("rst_uio_out", int'(uio_out), 0);
    check("rst_uio_oe", int'(uio_oe), 8'h80);
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    check("post_rst_uo_out", int'(uo_out), 0);

    op_lit("op45_17", 6'd45, 6'd17, 1'b0, 28, 0);
    op_lit("op5_9", 6'd5, 6'd9, 1'b0, 60, 1);
    op_lit("op0_0_1", 6'd0, 6'd0, 1'b1, 63, 1);
    op_lit("op63_63_1", 6'd63, 6'd63, 1'b1, 63, 1);
    op_lit("op63_0", 6'd63, 6'd0, 1'b0, 63, 0);

    // Busy lockout: re-pulse START with new operands mid-operation.
    @(negedge clk); ui_in = {2'b10, 6'd10}; uio_in = 8'd3;
    @(negedge clk); ui_in[7] = 0;
    wait_sig("lock_busy", 1'b1, 8);
    repeat (2) @(posedge clk);
    #1;
    check("lock_hold_d", int'(uo_out[5:0]), 63);
    check("lock_valid_low", int'(uo_out[7]), 0);
    @(negedge clk); ui_in = {2'b10, 6'd1}; uio_in = 8'd2;
    @(negedge clk); ui_in[7] = 0;
    wait_sig("lock_valid", 1'b0, 20);
    check("lock_d", int'(uo_out[5:0]), 7);
    check("lock_bout", int'(uo_out[6]), 0);
    b0 = brises;
    repeat (12) @(negedge clk);
    check("lock_no_second", brises - b0, 0);
    check("lock_valid_hold", int'(uo_out[7]), 1);

    // START held high for 20 cycles.
    b0 = brises; v0 = vrises;
    @(negedge clk); ui_in = {2'b10, 6'd20}; uio_in = 8'd5;
    repeat (20) @(negedge clk);
    check("held_one_accept", brises - b0, 1);
    check("held_one_valid", vrises - v0, 1);
    check("held_d", int'(uo_out[5:0]), 15);
    ui_in[7] = 0;
    repeat (3) @(negedge clk);
    op_lit("held_second", 6'd20, 6'd5, 1'b0, 15, 0);

    // Earliest back-to-back accept: second request lands 7 clocks later.
    b0 = brises;
    @(negedge clk); ui_in = {2'b10, 6'd7}; uio_in = 8'd2;
    @(negedge clk); ui_in[7] = 0;
    repeat (5) @(negedge clk);
    @(negedge clk); ui_in[7] = 1;
    @(negedge clk); ui_in[7] = 0;
    repeat (SYNC ? 2 : 0) @(negedge clk);
    check("b2b_busy", int'(uio_out[7]), 1);
    check("b2b_accepts", brises - b0, 2);
    wait_sig("b2b_valid", 1'b0, 20);
    check("b2b_d", int'(uo_out[5:0]), 5);

    // START toggling every cycle with random operands.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ui_in[6:0] = 7'($urandom); uio_in = 8'($urandom);
      ui_in[7] = ~ui_in[7];
    end
    @(negedge clk); ui_in[7] = 0;
    repeat (12) @(negedge clk);

    // Reset mid-operation with START held high through release.
    @(negedge clk); ui_in = {2'b10, 6'd33}; uio_in = 8'd11;
    wait_sig("rst_mid_busy", 1'b1, 8);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 0;
    #1;
    check("rst_mid_uo_out", int'(uo_out), 0);
    check("rst_mid_uio_out", int'(uio_out), 0);
    check("rst_mid_uio_oe", int'(uio_oe), 8'h80);
    @(negedge clk); rst_n = 1;
    b0 = brises;
    repeat (10) @(negedge clk);
    check("rst_rel_no_op", brises - b0, 0);
    check("rst_rel_uo_out", int'(uo_out), 0);
    ui_in[7] = 0;
    repeat (3) @(negedge clk);
    op_lit("rst_rel_op", 6'd33, 6'd11, 1'b0, 22, 0);

    // Random START/operand noise, checked cycle by cycle by the model.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ui_in = 8'($urandom); uio_in = 8'($urandom);
    end
    @(negedge clk); ui_in = 0;
    repeat (12) @(negedge clk);

    // Exhaustive sweep in a random permutation order.
    p = int'($urandom & 32'h1fff) | 1;
    off = int'($urandom & 32'h1fff);
    for (int i = 0; i < 8192; i++) begin
      idx = (i * p + off) & 8191;
      do_op(6'(idx), 6'(idx >> 6), idx[12], d, bout, lat);
      diff = (idx & 63) - ((idx >> 6) & 63) - ((idx >> 12) & 1);
      check("sweep_d", int'(d), (diff + 128) % 64);
      check("sweep_bout", int'(bout), int'(diff < 0));
      check("sweep_lat", lat, LAT);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
